// File: rtl/io_cond_pkg.sv
// rtl/io_cond_pkg.sv - shared debouncer state encoding and default timing values
package io_cond_pkg;

  localparam int TICK_DIV_DEFAULT  = 50_000_000;
  localparam int DB_CYCLES_DEFAULT = 500_000;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_e;

endpackage

// File: rtl/debounce_fsm.sv
// rtl/debounce_fsm.sv - two-flop synchronizer followed by a four-state debounce FSM
module debounce_fsm
  import io_cond_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic db_next
);

  localparam int CW = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);

  logic [1:0]    sync;
  logic          synced;
  db_state_e     state, state_n;
  logic [CW-1:0] count, count_n;

  assign synced = sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= 2'b00;
      state <= STABLE_LO;
      count <= '0;
    end else begin
      sync  <= {sync[0], raw};
      state <= state_n;
      count <= count_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    case (state)
      STABLE_LO: if (synced) begin
        state_n = WAIT_HI;
        count_n = CW'(1);
      end
      WAIT_HI: begin
        if (!synced) begin
          state_n = STABLE_LO;
          count_n = '0;
        end else if (count == DB_MAX) begin
          state_n = STABLE_HI;
          count_n = '0;
        end else begin
          count_n = count + CW'(1);
        end
      end
      STABLE_HI: if (!synced) begin
        state_n = WAIT_LO;
        count_n = CW'(1);
      end
      WAIT_LO: begin
        if (synced) begin
          state_n = STABLE_HI;
          count_n = '0;
        end else if (count == DB_MAX) begin
          state_n = STABLE_LO;
          count_n = '0;
        end else begin
          count_n = count + CW'(1);
        end
      end
      default: begin
        state_n = STABLE_LO;
        count_n = '0;
      end
    endcase
  end

  // The accepted level is a pure function of state; db_next lets the parent register edges in step.
  assign db      = (state == STABLE_HI) || (state == WAIT_LO);
  assign db_next = (state_n == STABLE_HI) || (state_n == WAIT_LO);

endmodule

// File: rtl/sw_tick_gen.sv
// rtl/sw_tick_gen.sv - debounced switch/button inputs and a restartable step-tick prescaler
module sw_tick_gen
  import io_cond_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEFAULT,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  input  logic btn_raw,
  output logic sw_db,
  output logic btn_db,
  output logic btn_rise,
  output logic tick
);

  localparam int TW = $clog2(TICK_DIV) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic          sw_db_next_unused;
  logic          btn_db_next;
  logic [TW-1:0] tick_cnt;

  debounce_fsm #(.DB_CYCLES(DB_CYCLES)) u_sw_db (
    .clk     (clk),
    .rst     (rst),
    .raw     (sw_raw),
    .db      (sw_db),
    .db_next (sw_db_next_unused)
  );

  debounce_fsm #(.DB_CYCLES(DB_CYCLES)) u_btn_db (
    .clk     (clk),
    .rst     (rst),
    .raw     (btn_raw),
    .db      (btn_db),
    .db_next (btn_db_next)
  );

  // A button press restarts the period, taking priority over a coinciding wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_rise <= 1'b0;
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      btn_rise <= btn_db_next & ~btn_db;
      if (btn_rise) begin
        tick_cnt <= '0;
        tick     <= 1'b0;
      end else if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
        tick     <= 1'b1;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
        tick     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sw_tick_gen.sv
// tb/tb_sw_tick_gen.sv - randomized and directed bench for sw_tick_gen against a behavioural model
module tb_sw_tick_gen;

  localparam int TD = 5;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw_raw = 1'b0;
  logic btn_raw = 1'b0;
  logic sw_db, btn_db, btn_rise, tick;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: a level is accepted after DB+1 consecutive differing synchronized samples.
  logic [1:0] h_sw = 2'b00;
  logic [1:0] h_btn = 2'b00;
  bit m_sw_db = 0, m_btn_db = 0, m_rise = 0, m_tick = 0;
  int run_sw = 0, run_btn = 0, since = 0;

  always #5 clk = ~clk;

  sw_tick_gen #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_raw   (sw_raw),
    .btn_raw  (btn_raw),
    .sw_db    (sw_db),
    .btn_db   (btn_db),
    .btn_rise (btn_rise),
    .tick     (tick)
  );

  task automatic db_model(input bit synced, inout bit lvl, inout int run);
    if (synced != lvl) begin
      run++;
      if (run == DB + 1) begin
        lvl = ~lvl;
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic step(input bit r, input bit s, input bit b);
    bit syn_sw, syn_btn, prev_btn, prev_rise;
    rst = r;
    sw_raw = s;
    btn_raw = b;
    @(posedge clk);
    if (r) begin
      h_sw = 2'b00; h_btn = 2'b00;
      m_sw_db = 0; m_btn_db = 0; m_rise = 0; m_tick = 0;
      run_sw = 0; run_btn = 0; since = 0;
    end else begin
      syn_sw = h_sw[1];
      syn_btn = h_btn[1];
      h_sw = {h_sw[0], s};
      h_btn = {h_btn[0], b};
      prev_rise = m_rise;
      prev_btn = m_btn_db;
      db_model(syn_sw, m_sw_db, run_sw);
      db_model(syn_btn, m_btn_db, run_btn);
      m_rise = m_btn_db & ~prev_btn;
      if (prev_rise) begin
        since = 0;
        m_tick = 0;
      end else begin
        since++;
        m_tick = (since % TD == 0);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 1; i <= 3; i++) begin
      step(1, 1, 0);
      n_cmp++;
      if ({sw_db, btn_db, btn_rise, tick} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_outputs cyc %0d: got %b want 0000", i, {sw_db, btn_db, btn_rise, tick});
      end
    end
    for (int n = 1; n <= 8; n++) begin
      step(0, 1, 0);
      n_cmp++;
      if (sw_db !== (n >= 7) || tick !== (n == 5)) begin
        n_fail++;
        $display("FAIL reset_release edge %0d: got sw_db=%b tick=%b want sw_db=%b tick=%b",
                 n, sw_db, tick, n >= 7, n == 5);
      end
    end
  endtask

  task automatic test_tick_free_run();
    step(1, 0, 0);
    for (int n = 1; n <= 30; n++) begin
      step(0, 0, 0);
      n_cmp++;
      if (tick !== (n % TD == 0) || tick !== m_tick) begin
        n_fail++;
        $display("FAIL tick_free_run edge %0d: got %b want %b", n, tick, n % TD == 0);
      end
    end
  endtask

  task automatic test_clean_switch();
    step(1, 0, 0);
    for (int n = 1; n <= 12; n++) begin
      step(0, n >= 3, 0);
      n_cmp++;
      if (sw_db !== (n >= 9) || sw_db !== m_sw_db) begin
        n_fail++;
        $display("FAIL clean_switch edge %0d: got %b want %b", n, sw_db, n >= 9);
      end
    end
  endtask

  task automatic test_bounce();
    int rises = 0;
    step(1, 0, 0);
    for (int n = 1; n <= 16; n++) begin
      step(0, 0, n != 4);
      if (btn_rise === 1'b1) rises++;
      n_cmp++;
      if (btn_db !== (n >= 11) || btn_rise !== (n == 11)) begin
        n_fail++;
        $display("FAIL bounce edge %0d: got btn_db=%b btn_rise=%b want btn_db=%b btn_rise=%b",
                 n, btn_db, btn_rise, n >= 11, n == 11);
      end
    end
    n_cmp++;
    if (rises != 1) begin
      n_fail++;
      $display("FAIL bounce_rise_count: got %0d want 1", rises);
    end
  endtask

  task automatic test_restart_collision();
    step(1, 0, 0);
    for (int n = 1; n <= 22; n++) begin
      step(0, 0, n >= 3);
      n_cmp++;
      if (btn_rise !== (n == 9) || tick !== (n == 5 || n == 15 || n == 20)) begin
        n_fail++;
        $display("FAIL restart_collision edge %0d: got rise=%b tick=%b want rise=%b tick=%b",
                 n, btn_rise, tick, n == 9, n == 5 || n == 15 || n == 20);
      end
    end
  endtask

  task automatic test_midop_reset();
    step(1, 0, 0);
    for (int n = 1; n <= 15; n++) begin
      if (n <= 4) step(0, 0, 1);
      else if (n == 5) step(1, 0, 1);
      else step(0, 0, 0);
      n_cmp++;
      if (btn_db !== 1'b0 || btn_rise !== 1'b0) begin
        n_fail++;
        $display("FAIL midop_reset edge %0d: got btn_db=%b btn_rise=%b want 0 0", n, btn_db, btn_rise);
      end
    end
  endtask

  task automatic test_random();
    bit s = 0, b = 0, r;
    int hold_sw = 0, hold_btn = 0;
    step(1, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      if (hold_sw == 0) begin s = ~s; hold_sw = $urandom_range(1, 9); end
      if (hold_btn == 0) begin b = ~b; hold_btn = $urandom_range(1, 9); end
      hold_sw--;
      hold_btn--;
      r = ($urandom_range(0, 199) == 0);
      step(r, s, b);
      n_cmp++;
      if ({sw_db, btn_db, btn_rise, tick} !== {m_sw_db, m_btn_db, m_rise, m_tick}) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b want %b", i,
                 {sw_db, btn_db, btn_rise, tick}, {m_sw_db, m_btn_db, m_rise, m_tick});
      end
    end
  endtask

  initial begin
    test_reset();
    test_tick_free_run();
    test_clean_switch();
    test_bounce();
    test_restart_collision();
    test_midop_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
